// File: rtl/alu_cond_stage.sv
// alu_cond_stage: condition evaluation, NZCV flag register and 2-entry valid/ready output buffer.
// Optional macro COND_STATS_EN adds ExecCount/SquashCount accept counters.
module alu_cond_stage #(
    parameter int         DATA_WIDTH = 32,
    parameter int         WA_WIDTH   = 4,
    parameter logic [3:0] FLAG_RST   = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  Negative,
    input  logic                  Zero,
    input  logic                  Carry,
    input  logic                  Overflow,
    input  logic [3:0]            Cond,
    input  logic [1:0]            FlagW,
    input  logic                  RegW,
    input  logic                  MemW,
    input  logic [WA_WIDTH-1:0]   WA3,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutResult,
    output logic                  OutRegW,
    output logic                  OutMemW,
    output logic [WA_WIDTH-1:0]   OutWA3,
    output logic                  OutCondEx,
    output logic [3:0]            Flags
`ifdef COND_STATS_EN
    ,
    output logic [31:0]           ExecCount,
    output logic [31:0]           SquashCount
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  regw;
        logic                  memw;
        logic [WA_WIDTH-1:0]   wa3;
        logic                  condex;
    } entry_t;

    entry_t     slot0_q, slot0_d, slot1_q, slot1_d, new_entry;
    logic [1:0] count_q, count_d;
    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;
    logic       cond_ex, accept, pop;

    assign {n, z, c, v} = flags_q;
    assign InReady      = (count_q != 2'd2) && reset_n;
    assign accept       = InValid & InReady;
    assign OutValid     = count_q != 2'd0;
    assign pop          = OutValid & OutReady;
    assign new_entry    = {ALUResult, RegW & cond_ex, MemW & cond_ex, WA3, cond_ex};
    assign OutResult    = slot0_q.result;
    assign OutRegW      = slot0_q.regw;
    assign OutMemW      = slot0_q.memw;
    assign OutWA3       = slot0_q.wa3;
    assign OutCondEx    = slot0_q.condex;
    assign Flags        = flags_q;

    // Condition check against the architectural flags, not the incoming ALU flags
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'h0:    cond_ex = z;
            4'h1:    cond_ex = !z;
            4'h2:    cond_ex = c;
            4'h3:    cond_ex = !c;
            4'h4:    cond_ex = n;
            4'h5:    cond_ex = !n;
            4'h6:    cond_ex = v;
            4'h7:    cond_ex = !v;
            4'h8:    cond_ex = c & !z;
            4'h9:    cond_ex = !c | z;
            4'hA:    cond_ex = n == v;
            4'hB:    cond_ex = n != v;
            4'hC:    cond_ex = !z & (n == v);
            4'hD:    cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    // Buffer: slot0 is always the head; a push lands in slot0 when it is (or is becoming) free
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q + 2'(accept) - 2'(pop);
        if (pop && count_q == 2'd2)
            slot0_d = slot1_q;
        if (accept) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop))
                slot0_d = new_entry;
            else
                slot1_d = new_entry;
        end
    end

    // Flags update only for accepted, executed instructions
    always_comb begin
        flags_d = flags_q;
        if (accept && cond_ex) begin
            if (FlagW[1])
                flags_d[3:2] = {Negative, Zero};
            if (FlagW[0])
                flags_d[1:0] = {Carry, Overflow};
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            flags_q <= FLAG_RST;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            flags_q <= flags_d;
        end
    end

`ifdef COND_STATS_EN
    logic [31:0] exec_q, exec_d, squash_q, squash_d;

    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;

    // Count accepted instructions split by condition outcome, wrapping naturally
    always_comb begin
        exec_d   = exec_q + 32'(accept & cond_ex);
        squash_d = squash_q + 32'(accept & !cond_ex);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end
`endif

endmodule
